// File: rtl/ct_fcnvt_i2f_vec_pipe_if.sv
// Handshake/data bundle for ct_fcnvt_i2f_vec_pipe.
// master drives beats and out_rdy; slave is the converter.
// The master and slave modports gain in_uns when FCNVT_UNSIGNED_EN is defined.
interface ct_fcnvt_i2f_vec_pipe_if #(
    parameter int LANES = 4,
    parameter int INT_W = 32
);
    logic                   in_vld;
    logic                   in_rdy;
    logic [LANES*INT_W-1:0] in_src;
    logic [LANES-1:0]       in_mask;
    logic [2:0]             in_rm;
`ifdef FCNVT_UNSIGNED_EN
    logic                   in_uns;
`endif
    logic                   out_vld;
    logic                   out_rdy;
    logic [LANES*32-1:0]    out_result;
    logic [4:0]             out_expt;

    modport master (
        output in_vld, in_src, in_mask, in_rm,
`ifdef FCNVT_UNSIGNED_EN
        output in_uns,
`endif
        output out_rdy,
        input  in_rdy, out_vld, out_result, out_expt
    );

    modport slave (
        input  in_vld, in_src, in_mask, in_rm,
`ifdef FCNVT_UNSIGNED_EN
        input  in_uns,
`endif
        input  out_rdy,
        output in_rdy, out_vld, out_result, out_expt
    );
endinterface

// File: rtl/ct_fcnvt_i2f_vec_pipe.sv
// LANES x INT_W integer to binary32 converter, 3-stage EX1/EX2/EX3 pipe.
// Ports: forever_cpuclk; cpurst (sync, active high); flush; vfpu_yy_xx_rm
//   (dynamic rm); io (slave): in_vld/in_rdy/in_src/in_mask/in_rm, out_vld/
//   out_rdy/out_result/out_expt {NV,DZ,OF,UF,NX}.
// Macro FCNVT_UNSIGNED_EN adds io.in_uns (treat operands as unsigned).
module ct_fcnvt_i2f_vec_pipe #(
    parameter int LANES = 4,
    parameter int INT_W = 32
) (
    input  logic                      forever_cpuclk,
    input  logic                      cpurst,
    input  logic                      flush,
    input  logic [2:0]                vfpu_yy_xx_rm,
    ct_fcnvt_i2f_vec_pipe_if.slave    io
);
    localparam int MW = INT_W + 1;

    logic ex1_adv, ex2_adv, ex3_adv, acc;
    logic ex1_vld_q, ex1_vld_d, ex2_vld_q, ex2_vld_d, ex3_vld_q, ex3_vld_d;

    logic [2:0]       ex1_rm_q, ex1_rm_d;
    logic [LANES-1:0] ex1_mask_q, ex1_mask_d, ex1_sign_q, ex1_sign_d;
    logic [MW-1:0]    ex1_mag_q [LANES];
    logic [MW-1:0]    ex1_mag_d [LANES];

    logic [2:0]       ex2_rm_q, ex2_rm_d;
    logic [LANES-1:0] ex2_mask_q, ex2_mask_d, ex2_sign_q, ex2_sign_d;
    logic [31:0]      ex2_norm_q [LANES];
    logic [31:0]      ex2_norm_d [LANES];
    logic [7:0]       ex2_exp_q [LANES];
    logic [7:0]       ex2_exp_d [LANES];

    logic [LANES*32-1:0] ex3_result_q, ex3_result_d;
    logic [4:0]          ex3_expt_q, ex3_expt_d;

    assign ex3_adv = !ex3_vld_q || io.out_rdy;
    assign ex2_adv = !ex2_vld_q || ex3_adv;
    assign ex1_adv = !ex1_vld_q || ex2_adv;
    assign acc     = io.in_vld && ex1_adv && !flush;

    assign io.in_rdy     = ex1_adv;
    assign io.out_vld    = ex3_vld_q;
    assign io.out_result = ex3_result_q;
    assign io.out_expt   = ex3_expt_q;

    always_comb begin
        ex1_vld_d = ex1_vld_q;
        ex2_vld_d = ex2_vld_q;
        ex3_vld_d = ex3_vld_q;
        if (flush) begin
            ex1_vld_d = 1'b0;
            ex2_vld_d = 1'b0;
            ex3_vld_d = 1'b0;
        end else begin
            if (ex1_adv) ex1_vld_d = io.in_vld;
            if (ex2_adv) ex2_vld_d = ex1_vld_q;
            if (ex3_adv) ex3_vld_d = ex2_vld_q;
        end
    end

    // EX1: resolve rm, split sign and magnitude (one extra bit for INT_MIN)
    always_comb begin
        logic [INT_W-1:0] src;
        logic             neg;
        src        = '0;
        neg        = 1'b0;
        ex1_rm_d   = (io.in_rm == 3'b111) ? vfpu_yy_xx_rm : io.in_rm;
        ex1_mask_d = io.in_mask;
        ex1_sign_d = '0;
        for (int l = 0; l < LANES; l++) begin
            src = io.in_src[l*INT_W +: INT_W];
            neg = src[INT_W-1];
`ifdef FCNVT_UNSIGNED_EN
            neg = neg && !io.in_uns;
`endif
            ex1_sign_d[l] = neg;
            ex1_mag_d[l]  = neg ? ({MW{1'b0}} - {src[INT_W-1], src})
                                : {1'b0, src};
        end
    end

    // EX2: find leading one, shift it to bit 31
    always_comb begin
        logic [31:0] m;
        logic [4:0]  msb;
        m          = '0;
        msb        = '0;
        ex2_rm_d   = ex1_rm_q;
        ex2_mask_d = ex1_mask_q;
        ex2_sign_d = ex1_sign_q;
        for (int l = 0; l < LANES; l++) begin
            m   = 32'(ex1_mag_q[l]);
            msb = '0;
            for (int i = 0; i < 32; i++) begin
                if (m[i]) msb = 5'(i);
            end
            ex2_norm_d[l] = m << (5'd31 - msb);
            ex2_exp_d[l]  = 8'd127 + {3'b000, msb};
        end
    end

    // EX3: round at bit 8; a carry out of the fraction ripples into exp
    always_comb begin
        logic        g, st, nx, inc, rsv, sgn;
        logic [30:0] mag;
        g            = 1'b0;
        st           = 1'b0;
        nx           = 1'b0;
        inc          = 1'b0;
        sgn          = 1'b0;
        mag          = '0;
        rsv          = (ex2_rm_q == 3'b101) || (ex2_rm_q == 3'b110);
        ex3_result_d = '0;
        ex3_expt_d   = '0;
        for (int l = 0; l < LANES; l++) begin
            sgn = ex2_sign_q[l];
            g   = ex2_norm_q[l][7];
            st  = |ex2_norm_q[l][6:0];
            nx  = g || st;
            case (ex2_rm_q)
                3'b000:  inc = g && (st || ex2_norm_q[l][8]);
                3'b010:  inc = sgn && nx;
                3'b011:  inc = !sgn && nx;
                3'b100:  inc = g;
                default: inc = 1'b0;
            endcase
            mag = {ex2_exp_q[l], ex2_norm_q[l][30:8]} + {30'b0, inc};
            if (ex2_mask_q[l]) begin
                if (rsv) begin
                    ex3_expt_d[4] = 1'b1;
                end else if (ex2_norm_q[l][31]) begin
                    ex3_result_d[l*32 +: 32] = {sgn, mag};
                    ex3_expt_d[0] = ex3_expt_d[0] || nx;
                end
            end
        end
    end

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            ex1_vld_q    <= 1'b0;
            ex2_vld_q    <= 1'b0;
            ex3_vld_q    <= 1'b0;
            ex3_result_q <= '0;
            ex3_expt_q   <= '0;
        end else begin
            ex1_vld_q <= ex1_vld_d;
            ex2_vld_q <= ex2_vld_d;
            ex3_vld_q <= ex3_vld_d;
            if (ex3_adv && ex2_vld_q) begin
                ex3_result_q <= ex3_result_d;
                ex3_expt_q   <= ex3_expt_d;
            end
        end
    end

    always_ff @(posedge forever_cpuclk) begin
        if (acc) begin
            ex1_rm_q   <= ex1_rm_d;
            ex1_mask_q <= ex1_mask_d;
            ex1_sign_q <= ex1_sign_d;
            for (int l = 0; l < LANES; l++) ex1_mag_q[l] <= ex1_mag_d[l];
        end
        if (ex2_adv && ex1_vld_q) begin
            ex2_rm_q   <= ex2_rm_d;
            ex2_mask_q <= ex2_mask_d;
            ex2_sign_q <= ex2_sign_d;
            for (int l = 0; l < LANES; l++) begin
                ex2_norm_q[l] <= ex2_norm_d[l];
                ex2_exp_q[l]  <= ex2_exp_d[l];
            end
        end
    end
endmodule

// File: tb/tb_ct_fcnvt_i2f_vec_pipe.sv
// Testbench for ct_fcnvt_i2f_vec_pipe: directed literal beats plus random
// traffic against an arithmetic reference model and in-order scoreboard.
module tb_ct_fcnvt_i2f_vec_pipe;
    localparam int LANES = 4;
    localparam int INT_W = 32;

    logic       forever_cpuclk = 1'b0;
    logic       cpurst;
    logic       flush;
    logic [2:0] vfpu_yy_xx_rm;

    ct_fcnvt_i2f_vec_pipe_if #(.LANES(LANES), .INT_W(INT_W)) io ();

    ct_fcnvt_i2f_vec_pipe #(.LANES(LANES), .INT_W(INT_W)) dut (
        .forever_cpuclk (forever_cpuclk),
        .cpurst         (cpurst),
        .flush          (flush),
        .vfpu_yy_xx_rm  (vfpu_yy_xx_rm),
        .io             (io)
    );

    always #5 forever_cpuclk = ~forever_cpuclk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int n_out = 0;
    bit mon_en = 0;
    bit saw_stall = 0;

    always @(posedge forever_cpuclk) cyc <= cyc + 1;

    typedef struct {
        logic [127:0] res;
        logic [4:0]   expt;
        int           acc;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string nm, input logic [159:0] got,
                       input logic [159:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", nm, got, want);
        end
    endtask

    // Returns {NV, NX, binary32}; rounding from remainder vs half-ulp.
    function automatic logic [33:0] ref_lane(input logic [31:0] src,
                                             input logic [2:0] rm);
        longint v;
        longint unsigned a, q, rem, half;
        int e, s;
        bit neg, inc;
        if (rm == 3'd5 || rm == 3'd6) return {2'b10, 32'h0};
        v = $signed(src);
        if (v == 0) return '0;
        neg = (v < 0);
        a = neg ? -v : v;
        e = 0;
        while ((a >> (e + 1)) != 0) e++;
        if (e <= 23) begin
            q = a << (23 - e);
            rem = 0;
            half = 1;
        end else begin
            s = e - 23;
            q = a >> s;
            rem = a - (q << s);
            half = 64'd1 << (s - 1);
        end
        case (rm)
            3'd0:    inc = (rem > half) || (rem == half && q[0]);
            3'd1:    inc = 0;
            3'd2:    inc = neg && rem != 0;
            3'd3:    inc = !neg && rem != 0;
            default: inc = (rem >= half) && rem != 0;
        endcase
        q = q + 64'(inc);
        if ((q >> 24) != 0) begin
            q = q >> 1;
            e++;
        end
        return {1'b0, rem != 0, neg, 8'(e + 127), q[22:0]};
    endfunction

    function automatic exp_t model_beat(input logic [127:0] src,
                                        input logic [3:0] mask,
                                        input logic [2:0] rm,
                                        input logic [2:0] vrm,
                                        input int acc);
        exp_t x;
        logic [33:0] r;
        logic [2:0] m;
        m = (rm == 3'b111) ? vrm : rm;
        x.res = '0;
        x.expt = '0;
        x.acc = acc;
        for (int l = 0; l < LANES; l++) begin
            if (mask[l]) begin
                r = ref_lane(src[l*32 +: 32], m);
                x.res[l*32 +: 32] = r[31:0];
                x.expt[4] = x.expt[4] | r[33];
                x.expt[0] = x.expt[0] | r[32];
            end
        end
        return x;
    endfunction

    // Compare process: in_rdy, hold stability, in-order results.
    bit           stall_prev = 0;
    logic [127:0] hold_res;
    logic [4:0]   hold_expt;

    always @(negedge forever_cpuclk) begin
        exp_t e;
        if (mon_en) begin
            chk("in_rdy", io.in_rdy, (sb.size() < 3) || io.out_rdy);
            if (!io.in_rdy) saw_stall = 1;
            if (stall_prev) begin
                chk("hold_vld", io.out_vld, 1'b1);
                chk("hold_res", io.out_result, hold_res);
                chk("hold_expt", io.out_expt, hold_expt);
            end
            stall_prev = io.out_vld && !io.out_rdy && !flush && !cpurst;
            hold_res = io.out_result;
            hold_expt = io.out_expt;
            if (io.out_vld === 1'b1) begin
                chk("no_spurious_out", sb.size() != 0, 1'b1);
                if (sb.size() != 0 && io.out_rdy && !flush && !cpurst) begin
                    e = sb.pop_front();
                    n_out++;
                    chk("sb_res", io.out_result, e.res);
                    chk("sb_expt", io.out_expt, e.expt);
                    chk("latency_min", (cyc - e.acc) >= 3, 1'b1);
                end
            end
            if (cpurst || flush) sb.delete();
            else if (io.in_vld && io.in_rdy)
                sb.push_back(model_beat(io.in_src, io.in_mask, io.in_rm,
                                        vfpu_yy_xx_rm, cyc));
        end
    end

    task automatic send(input logic [127:0] src, input logic [3:0] mask,
                        input logic [2:0] rm, output int acc_cyc);
        int n;
        n = 0;
        io.in_vld = 1;
        io.in_src = src;
        io.in_mask = mask;
        io.in_rm = rm;
        @(negedge forever_cpuclk);
        while (!io.in_rdy && n < 50) begin
            n++;
            @(negedge forever_cpuclk);
        end
        if (!io.in_rdy) chk("send_timeout", io.in_rdy, 1'b1);
        acc_cyc = cyc;
        @(posedge forever_cpuclk);
        #1;
        io.in_vld = 0;
    endtask

    task automatic wait_out(output int c);
        int n;
        n = 0;
        c = -1;
        while (n < 20) begin
            @(negedge forever_cpuclk);
            if (io.out_vld === 1'b1) begin
                c = cyc;
                break;
            end
            n++;
        end
        if (c < 0) chk("out_timeout", io.out_vld, 1'b1);
    endtask

    task automatic dir_check(input string nm, input logic [127:0] src,
                             input logic [3:0] mask, input logic [2:0] rm,
                             input logic [2:0] vrm, input logic [127:0] er,
                             input logic [4:0] ee, output int lat);
        int a, c;
        vfpu_yy_xx_rm = vrm;
        send(src, mask, rm, a);
        wait_out(c);
        chk({nm, "_res"}, io.out_result, er);
        chk({nm, "_expt"}, io.out_expt, ee);
        lat = c - a;
        @(posedge forever_cpuclk);
        #1;
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] v;
        case ($urandom_range(0, 6))
            0: v = $urandom;
            1: v = $urandom_range(0, 255);
            2: v = 32'h0;
            3: v = 32'h80000000;
            4: v = 32'h7FFFFFFF ^ $urandom_range(0, 255);
            5: v = 32'h01000000 | $urandom_range(0, 3);
            default: v = -($urandom_range(0, 1 << 26));
        endcase
        return v;
    endfunction

    logic [31:0]  d_src [8] = '{32'h01000001, 32'h01000001, 32'h01000001,
                                32'hFEFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF,
                                32'h7FFFFFFF, 32'h7FFFFFFF};
    logic [2:0]   d_rm  [8] = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd0, 3'd1, 3'd7, 3'd5};
    logic [2:0]   d_vrm [8] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd0};
    logic [31:0]  d_res [8] = '{32'h4B800000, 32'h4B800001, 32'h4B800000,
                                32'hCB800001, 32'h4F000000, 32'h4EFFFFFF,
                                32'h4EFFFFFF, 32'h00000000};
    logic [4:0]   d_ex  [8] = '{5'h01, 5'h01, 5'h01, 5'h01, 5'h01, 5'h01,
                                5'h01, 5'h10};

    initial begin
        int lat, a, n, base;
        bit seen, done;
        logic [127:0] s;

        cpurst = 1;
        flush = 0;
        vfpu_yy_xx_rm = 0;
        io.in_vld = 0;
        io.in_src = '0;
        io.in_mask = '0;
        io.in_rm = '0;
        io.out_rdy = 1;
`ifdef FCNVT_UNSIGNED_EN
        io.in_uns = 0;
`endif
        chk("pin_one", ref_lane(32'h1, 3'd0), {2'b00, 32'h3F800000});
        chk("pin_m1", ref_lane(32'hFFFFFFFF, 3'd0), {2'b00, 32'hBF800000});
        chk("pin_min", ref_lane(32'h80000000, 3'd0), {2'b00, 32'hCF000000});
        chk("pin_tie", ref_lane(32'h01000001, 3'd0), {2'b01, 32'h4B800000});
        chk("pin_rtz", ref_lane(32'h7FFFFFFF, 3'd1), {2'b01, 32'h4EFFFFFF});
        chk("pin_rsv", ref_lane(32'h7FFFFFFF, 3'd6), {2'b10, 32'h0});

        repeat (3) @(posedge forever_cpuclk);
        #1;
        cpurst = 0;
        @(negedge forever_cpuclk);
        chk("rst_out_vld", io.out_vld, 1'b0);
        chk("rst_result", io.out_result, 128'h0);
        chk("rst_expt", io.out_expt, 5'h0);
        chk("rst_in_rdy", io.in_rdy, 1'b1);
        mon_en = 1;
        @(posedge forever_cpuclk);
        #1;

        dir_check("basic", {32'h80000000, 32'h0, 32'hFFFFFFFF, 32'h1},
                  4'hF, 3'd0, 3'd0,
                  {32'hCF000000, 32'h0, 32'hBF800000, 32'h3F800000},
                  5'h0, lat);
        chk("latency3", lat, 3);

        for (int i = 0; i < 8; i++)
            dir_check($sformatf("dir%0d", i), {4{d_src[i]}}, 4'hF, d_rm[i],
                      d_vrm[i], {4{d_res[i]}}, d_ex[i], lat);

        dir_check("mask", {32'h01000001, 32'h2, 32'h01000001, 32'h1},
                  4'b0101, 3'd0, 3'd0,
                  {32'h0, 32'h40000000, 32'h0, 32'h3F800000}, 5'h0, lat);

        // backpressure: 6 beats, out_rdy low for 4 cycles
        saw_stall = 0;
        base = n_out;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    s = {pick(), pick(), pick(), pick()};
                    send(s, 4'hF, 3'd0, a);
                end
            end
            begin
                repeat (2) @(posedge forever_cpuclk);
                #1;
                io.out_rdy = 0;
                repeat (4) @(posedge forever_cpuclk);
                #1;
                io.out_rdy = 1;
            end
        join
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge forever_cpuclk);
            n++;
        end
        chk("bp_stall_seen", saw_stall, 1'b1);
        chk("bp_count", n_out - base, 6);
        @(posedge forever_cpuclk);
        #1;

        // flush with two beats in flight and a same-cycle input
        send({4{32'h5}}, 4'hF, 3'd0, a);
        send({4{32'h6}}, 4'hF, 3'd0, a);
        flush = 1;
        io.in_vld = 1;
        io.in_src = {4{32'h7}};
        @(negedge forever_cpuclk);
        chk("flush_in_rdy", io.in_rdy, 1'b1);
        @(posedge forever_cpuclk);
        #1;
        flush = 0;
        io.in_vld = 0;
        seen = 0;
        repeat (6) begin
            @(negedge forever_cpuclk);
            if (io.out_vld) seen = 1;
        end
        chk("flush_no_out", seen, 1'b0);
        @(posedge forever_cpuclk);
        #1;
        dir_check("post_flush", {4{32'h3}}, 4'hF, 3'd0, 3'd0,
                  {4{32'h40400000}}, 5'h0, lat);

        // reset mid-stream
        send({4{32'h9}}, 4'hF, 3'd0, a);
        send({4{32'hA}}, 4'hF, 3'd0, a);
        cpurst = 1;
        io.in_vld = 1;
        @(posedge forever_cpuclk);
        #1;
        cpurst = 0;
        io.in_vld = 0;
        seen = 0;
        repeat (6) begin
            @(negedge forever_cpuclk);
            if (io.out_vld) seen = 1;
        end
        chk("rst_no_out", seen, 1'b0);
        chk("rst_empty_rdy", io.in_rdy, 1'b1);
        @(posedge forever_cpuclk);
        #1;

        // random traffic with random stalls
        done = 0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    s = {pick(), pick(), pick(), pick()};
                    vfpu_yy_xx_rm = 3'($urandom_range(0, 6));
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge forever_cpuclk);
                        #1;
                    end
                    send(s, 4'($urandom_range(0, 15)),
                         3'($urandom_range(0, 7)), a);
                end
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge forever_cpuclk);
                    #1;
                    io.out_rdy = ($urandom_range(0, 3) != 0);
                end
                io.out_rdy = 1;
            end
        join
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge forever_cpuclk);
            n++;
        end
        chk("drain", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end
endmodule
